adder_measure_ctrl: RTL and testbench

ADDER_MEASURE_CTRL -- requirements
Module: adder_measure_ctrl

---
 rtl/adder_measure_ctrl.sv | 164 ++++++++++++++++
 tb/tb_adder_measure_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_measure_ctrl.sv
// -----------------------------------------------------------------------------
// adder_measure_ctrl
//
// Sequences one delay measurement of an instrumented adder. The operands are
// captured on an accepted start and driven into the adder. The adder's
// ring-oscillator chain is then enabled for 'window' cycles. Rising edges of
// the ring tap are counted through a two-flop synchronizer. Finally the
// adder's sum is checked against the captured operands.
//
// Ports
//   wb_clk_i    sole clock, rising edge
//   wb_rst_i    asynchronous, active-high reset
//   active      block enable; low aborts any measurement back to IDLE
//   start       one-cycle request, accepted only in IDLE with active high
//   a_in, b_in  operands captured on the accepted start
//   window      number of cycles the ring oscillator runs
//   dut_a/b     captured operands, held until the next accepted start
//   dut_run     ring-oscillator enable
//   dut_sum     sum returned by the adder under test
//   ring_pulse  raw ring tap, asynchronous to wb_clk_i
//   busy, done  busy outside IDLE; done is a one-cycle completion pulse
//   ring_count  saturating count of synchronized ring rising edges
//   sum_ok      dut_sum matched a+b (mod 2^32) during CHECK
// -----------------------------------------------------------------------------
module adder_measure_ctrl (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        active,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic [15:0] window,
   output logic [31:0] dut_a,
   output logic [31:0] dut_b,
   output logic        dut_run,
   input  logic [31:0] dut_sum,
   input  logic        ring_pulse,
   output logic        busy,
   output logic        done,
   output logic [31:0] ring_count,
   output logic        sum_ok
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_CHECK, S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;        // cycles spent in the current state
   logic [15:0] win_q, win_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [1:0]  sync_q, sync_d;     // [0] metastability stage, [1] stable
   logic        prev_q, prev_d;     // previous synchronized value for edges
   logic [31:0] count_q, count_d;
   logic        sum_ok_q, sum_ok_d;

   logic        rise;
   logic [31:0] exp_sum;

   assign rise    = sync_q[1] & ~prev_q;
   assign exp_sum = a_q + b_q;       // carry-out intentionally dropped

   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q + 16'd1;
      win_d    = win_q;
      a_d      = a_q;
      b_d      = b_q;
      sync_d   = {sync_q[0], ring_pulse};
      prev_d   = sync_q[1];
      count_d  = count_q;
      sum_ok_d = sum_ok_q;

      // DRAIN keeps counting so edges still inside the synchronizer at the
      // end of RUN are not lost.
      if ((state_q == S_RUN || state_q == S_DRAIN) && rise && count_q != 32'hFFFF_FFFF)
         count_d = count_q + 32'd1;

      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (start && active) begin
               state_d  = S_SETUP;
               a_d      = a_in;
               b_d      = b_in;
               win_d    = window;
               count_d  = 32'd0;
               sum_ok_d = 1'b0;
            end
         end
         S_SETUP: begin
            if (cnt_q == 16'd1) begin
               cnt_d   = 16'd0;
               state_d = (win_q == 16'd0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            // win_q is non-zero here; a zero window bypasses RUN.
            if (cnt_q == win_q - 16'd1) begin
               cnt_d   = 16'd0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cnt_q == 16'd2) begin
               cnt_d   = 16'd0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            sum_ok_d = (dut_sum == exp_sum);
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Dropping the enable aborts from any state and discards the result.
      if (state_q != S_IDLE && !active) begin
         state_d  = S_IDLE;
         cnt_d    = 16'd0;
         sum_ok_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         win_q    <= 16'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         sync_q   <= 2'b00;
         prev_q   <= 1'b0;
         count_q  <= 32'd0;
         sum_ok_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge
         // values; the synchronizer chain depends on this ordering.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         count_q  <= count_d;
         sum_ok_q <= sum_ok_d;
      end
   end

   // dut_run and done are gated by active combinationally so an abort takes
   // effect in the same cycle, before the state register catches up.
   assign dut_run    = (state_q == S_RUN) && active;
   assign done       = (state_q == S_DONE) && active;
   assign busy       = (state_q != S_IDLE);
   assign dut_a      = a_q;
   assign dut_b      = b_q;
   assign ring_count = count_q;
   assign sum_ok     = sum_ok_q;

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_measure_ctrl
//
// The bench plays the part of the instrumented adder. dut_sum is dut_a + dut_b
// plus an injectable error term. The ring oscillator is modelled as well: it
// only toggles while dut_run is high. Every rising edge it produces must be
// counted exactly once, so the reference ring count is the number of 0->1
// transitions the bench drove during the measurement. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adder_measure_ctrl;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic        active, start;
   logic [31:0] a_in, b_in;
   logic [15:0] window;
   logic [31:0] dut_a, dut_b, dut_sum;
   logic        dut_run, ring_pulse;
   logic        busy, done, sum_ok;
   logic [31:0] ring_count;

   logic [31:0] sum_err = 32'd0;
   int          pulse_mode = 0;     // 0 static low, 1 random, 2 toggle every 4 cycles
   int          edge_total = 0;
   int          ph = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   assign dut_sum = dut_a + dut_b + sum_err;

   adder_measure_ctrl u_dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (wb_rst_i),
      .active     (active),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .window     (window),
      .dut_a      (dut_a),
      .dut_b      (dut_b),
      .dut_run    (dut_run),
      .dut_sum    (dut_sum),
      .ring_pulse (ring_pulse),
      .busy       (busy),
      .done       (done),
      .ring_count (ring_count),
      .sum_ok     (sum_ok)
   );

   // Ring oscillator model: it runs only while enabled and counts its own edges.
   initial ring_pulse = 1'b0;
   always @(negedge clk) begin
      logic nxt;
      nxt = 1'b0;
      if (dut_run) begin
         if (pulse_mode == 1) nxt = 1'($urandom_range(0, 1));
         else if (pulse_mode == 2) nxt = (ph % 4 == 0) ? ~ring_pulse : ring_pulse;
         ph = ph + 1;
      end else begin
         ph = 0;
      end
      if (nxt && !ring_pulse) edge_total = edge_total + 1;
      ring_pulse = nxt;
   end

   // Runs one measurement from IDLE for a fixed number of cycles and records
   // what the outputs did. k counts cycles after the start cycle.
   task automatic measure(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w,
                          input logic [31:0] err, input int mode, input int restart_at,
                          output int first_done, output int n_done, output int n_run,
                          output int ops_bad, output logic busy_after, output int edges);
      int e0;
      int n;
      n = int'(w) + 12;
      @(negedge clk);
      sum_err = err; pulse_mode = mode;
      a_in = a; b_in = b; window = w; active = 1'b1; start = 1'b1;
      e0 = edge_total;
      first_done = -1; n_done = 0; n_run = 0; ops_bad = 0; busy_after = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (k == restart_at) begin
            a_in = ~a; b_in = ~b; window = w + 16'd5;
         end
         if (dut_run) n_run++;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
         if (first_done >= 0 && k == first_done + 1) busy_after = busy;
         if (busy && (dut_a !== a || dut_b !== b)) ops_bad++;
      end
      edges = edge_total - e0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1; active = 1'b0; start = 1'b0;
      a_in = 32'd0; b_in = 32'd0; window = 16'd0;
      #1;
      checks++;
      if ({dut_a, dut_b} !== 64'd0) begin failures++; $display("FAIL reset_ops: got %h/%h want 0/0", dut_a, dut_b); end
      checks++;
      if ({dut_run, busy, done, sum_ok} !== 4'b0) begin
         failures++; $display("FAIL reset_flags: run/busy/done/ok got %b%b%b%b want 0000", dut_run, busy, done, sum_ok);
      end
      checks++;
      if (ring_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", ring_count); end
      repeat (3) @(negedge clk);
      wb_rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int fd, nd, nr, ob, ed; logic ba;
      measure(32'd3, 32'd5, 16'd10, 32'd0, 2, -1, fd, nd, nr, ob, ba, ed);
      checks++; if (fd !== 17) begin failures++; $display("FAIL basic_latency: got %0d want 17", fd); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", nd); end
      checks++; if (nr !== 10) begin failures++; $display("FAIL basic_run_cycles: got %0d want 10", nr); end
      checks++; if (sum_ok !== 1'b1) begin failures++; $display("FAIL basic_sum_ok: got %b want 1", sum_ok); end
      checks++; if (ring_count !== 32'(ed)) begin failures++; $display("FAIL basic_ring_count: got %0d want %0d", ring_count, ed); end
      checks++; if (ob !== 0) begin failures++; $display("FAIL basic_operands: %0d bad cycles want 0", ob); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", ba); end
   endtask

   task automatic test_wrap();
      int fd, nd, nr, ob, ed; logic ba;
      measure(32'hFFFF_FFFF, 32'd1, 16'd4, 32'd0, 1, -1, fd, nd, nr, ob, ba, ed);
      checks++; if (sum_ok !== 1'b1) begin failures++; $display("FAIL wrap_sum_ok: got %b want 1", sum_ok); end
      checks++; if (fd !== 11) begin failures++; $display("FAIL wrap_latency: got %0d want 11", fd); end
      measure(32'hFFFF_FFFF, 32'd1, 16'd4, 32'd1, 1, -1, fd, nd, nr, ob, ba, ed);
      checks++; if (sum_ok !== 1'b0) begin failures++; $display("FAIL wrap_bad_sum: got %b want 0", sum_ok); end
      checks++; if (ring_count !== 32'(ed)) begin failures++; $display("FAIL wrap_ring_count: got %0d want %0d", ring_count, ed); end
   endtask

   task automatic test_window_zero();
      int fd, nd, nr, ob, ed; logic ba;
      measure(32'd100, 32'd23, 16'd0, 32'd0, 0, -1, fd, nd, nr, ob, ba, ed);
      checks++; if (nr !== 0) begin failures++; $display("FAIL zero_run: dut_run cycles got %0d want 0", nr); end
      checks++; if (fd !== 7) begin failures++; $display("FAIL zero_latency: got %0d want 7", fd); end
      checks++; if (ring_count !== 32'd0) begin failures++; $display("FAIL zero_count: got %0d want 0", ring_count); end
      checks++; if (sum_ok !== 1'b1) begin failures++; $display("FAIL zero_sum_ok: got %b want 1", sum_ok); end
   endtask

   task automatic test_start_ignored();
      int fd, nd, nr, ob, ed; logic ba;
      measure(32'hDEAD_0001, 32'h0000_BEEF, 16'd8, 32'd0, 1, 3, fd, nd, nr, ob, ba, ed);
      checks++; if (fd !== 15) begin failures++; $display("FAIL busy_start_latency: got %0d want 15", fd); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL busy_start_dones: got %0d want 1", nd); end
      checks++; if (ob !== 0) begin failures++; $display("FAIL busy_start_operands: %0d bad cycles want 0", ob); end
      checks++; if (nr !== 8) begin failures++; $display("FAIL busy_start_run: got %0d want 8", nr); end
   endtask

   task automatic test_back_to_back();
      int fd, nd, nr, ob, ed; logic ba;
      // A start presented during DONE (k = w + 7) must not be taken.
      measure(32'd77, 32'd88, 16'd3, 32'd0, 1, 10, fd, nd, nr, ob, ba, ed);
      checks++; if (nd !== 1) begin failures++; $display("FAIL done_start_dones: got %0d want 1", nd); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL done_start_busy: got %b want 0", ba); end
      checks++; if (dut_a !== 32'd77) begin failures++; $display("FAIL done_start_hold: dut_a got %0d want 77", dut_a); end
   endtask

   task automatic test_abort_active();
      int nd;
      @(negedge clk);
      pulse_mode = 1; sum_err = 32'd0;
      a_in = 32'd7; b_in = 32'd9; window = 16'd20; active = 1'b1; start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      // k = 7 is the fifth cycle of RUN.
      checks++; if (dut_run !== 1'b1) begin failures++; $display("FAIL abort_pre_run: got %b want 1", dut_run); end
      active = 1'b0;
      #1;
      checks++; if (dut_run !== 1'b0) begin failures++; $display("FAIL abort_run_gate: got %b want 0", dut_run); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle: busy got %b want 0", busy); end
      checks++; if (sum_ok !== 1'b0) begin failures++; $display("FAIL abort_sum_ok: got %b want 0", sum_ok); end
      active = 1'b1;
      nd = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) nd++;
      end
      checks++; if (nd !== 0) begin failures++; $display("FAIL abort_no_done: got %0d want 0", nd); end
   endtask

   task automatic test_reset_mid_run();
      int fd, nd, nr, ob, ed; logic ba;
      @(negedge clk);
      pulse_mode = 1; sum_err = 32'd0;
      a_in = 32'h0000_1234; b_in = 32'h0000_5678; window = 16'd20; active = 1'b1; start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 wb_rst_i = 1'b1;
      #1;
      checks++;
      if ({dut_a, dut_b, ring_count} !== 96'd0) begin
         failures++; $display("FAIL rst_mid_values: a/b/count got %h/%h/%0d want 0/0/0", dut_a, dut_b, ring_count);
      end
      checks++;
      if ({dut_run, busy, done, sum_ok} !== 4'b0) begin
         failures++; $display("FAIL rst_mid_flags: run/busy/done/ok got %b%b%b%b want 0000", dut_run, busy, done, sum_ok);
      end
      @(negedge clk);
      wb_rst_i = 1'b0;
      measure(32'd11, 32'd22, 16'd2, 32'd0, 1, -1, fd, nd, nr, ob, ba, ed);
      checks++; if (fd !== 9) begin failures++; $display("FAIL rst_post_latency: got %0d want 9", fd); end
      checks++; if (sum_ok !== 1'b1) begin failures++; $display("FAIL rst_post_sum_ok: got %b want 1", sum_ok); end
      checks++; if (ring_count !== 32'(ed)) begin failures++; $display("FAIL rst_post_count: got %0d want %0d", ring_count, ed); end
   endtask

   task automatic test_random();
      int fd, nd, nr, ob, ed; logic ba;
      logic [31:0] a, b, err;
      logic [15:0] w;
      for (int i = 0; i < 10; i++) begin
         a   = $urandom;
         b   = $urandom;
         w   = 16'($urandom_range(0, 14));
         err = ($urandom_range(0, 2) == 0) ? ($urandom | 32'd1) : 32'd0;
         measure(a, b, w, err, 1, -1, fd, nd, nr, ob, ba, ed);
         checks++;
         if (fd !== int'(w) + 7 || nd !== 1) begin
            failures++; $display("FAIL rand_latency[%0d]: w=%0d done at %0d (x%0d) want %0d (x1)", i, w, fd, nd, int'(w) + 7);
         end
         checks++;
         if (nr !== int'(w)) begin failures++; $display("FAIL rand_run[%0d]: got %0d want %0d", i, nr, w); end
         checks++;
         if (sum_ok !== (err == 32'd0)) begin
            failures++; $display("FAIL rand_sum_ok[%0d]: got %b want %b", i, sum_ok, err == 32'd0);
         end
         checks++;
         if (ring_count !== 32'(ed)) begin
            failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, ring_count, ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_window_zero();
      test_start_ignored();
      test_back_to_back();
      test_abort_active();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
